sfx_scheduler: RTL and testbench

Arbitrates game sound-effect requests (bullet, hit, explosion, game-over, ...) onto one shared square-wave tone generator. Each requester has a fixed tone divider and duration, and requests are served by fixed priority. A higher-priority request preempts the effect that is playing. Output `audio` is the SFX input of the audio mixer; `busy` ducks the background music.

---
 rtl/sfx_scheduler.sv | 176 +++++++++++++++++
 tb/tb_sfx_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sound-effect arbiter driving one square-wave tone.
// Ports: clk, rst_n (sync, active-low), req[NUM_REQ] (edge-detected triggers),
//   vol_num[4] (live volume), audio[16] (signed sample, 0 when silent),
//   busy (effect playing), cur_id (last granted source), ack (grant pulse),
//   done (natural-completion pulse).
module sfx_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DIV_W = 22,
  parameter int DUR_W = 32,
  parameter logic [NUM_REQ*DIV_W-1:0] DIV_TABLE =
    {22'd60000, 22'd75000, 22'd90000, 22'd120000},
  parameter logic [NUM_REQ*DUR_W-1:0] DUR_TABLE = {4{32'd5000000}},
  parameter logic [15:0] GAP_CYCLES = 16'd1000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [3:0]                 vol_num,
  output logic [15:0]                audio,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] cur_id,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       done
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [NUM_REQ-1:0] pend, pend_n;
  logic [NUM_REQ-1:0] req_prev;
  logic [DUR_W-1:0]   dur_cnt, dur_n;
  logic [DIV_W-1:0]   half_cnt, half_n;
  logic [DIV_W-1:0]   div_r, div_n;
  logic               phase, phase_n;
  logic [15:0]        gap_cnt, gap_n;
  logic [IW-1:0]      id_n;
  logic [NUM_REQ-1:0] ack_n;
  logic               done_n;

  logic [NUM_REQ-1:0] rise;
  logic [IW-1:0]      gnt;
  logic               gnt_v;
  logic               load;
  logic [DIV_W-1:0]   div_raw, ld_div;
  logic [DUR_W-1:0]   dur_raw, ld_dur;
  logic [15:0]        amp_p, amp_n;

  assign rise  = req & ~req_prev;
  assign gnt_v = |pend;

  // Lowest set index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) gnt = IW'(i);
    end
  end

  assign div_raw = DIV_TABLE[int'(gnt)*DIV_W +: DIV_W];
  assign dur_raw = DUR_TABLE[int'(gnt)*DUR_W +: DUR_W];
  assign ld_div  = (div_raw == '0) ? DIV_W'(1) : div_raw;
  assign ld_dur  = (dur_raw == '0) ? DUR_W'(1) : dur_raw;

  always_comb begin
    amp_p = 16'h0400;
    amp_n = 16'hFC00;
    case (vol_num)
      4'd5: begin amp_p = 16'h4000; amp_n = 16'hC000; end
      4'd4: begin amp_p = 16'h3000; amp_n = 16'hD000; end
      4'd3: begin amp_p = 16'h2000; amp_n = 16'hE000; end
      4'd2: begin amp_p = 16'h1000; amp_n = 16'hF000; end
      4'd1: begin amp_p = 16'h0800; amp_n = 16'hF800; end
      4'd0: begin amp_p = 16'h0000; amp_n = 16'h0000; end
      default: begin amp_p = 16'h0400; amp_n = 16'hFC00; end
    endcase
  end

  assign busy  = (state == S_PLAY);
  assign audio = busy ? (phase ? amp_p : amp_n) : 16'h0000;

  always_comb begin
    state_n = state;
    pend_n  = pend;
    dur_n   = dur_cnt;
    half_n  = half_cnt;
    div_n   = div_r;
    phase_n = phase;
    gap_n   = gap_cnt;
    id_n    = cur_id;
    ack_n   = '0;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      S_IDLE: load = gnt_v;
      S_PLAY: begin
        // Completion outranks any preempt/retrigger seen on the same edge.
        if (dur_cnt <= DUR_W'(1)) begin
          done_n = 1'b1;
          dur_n  = '0;
          if (GAP_CYCLES == 16'd0) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_GAP;
            gap_n   = GAP_CYCLES;
          end
        end else if (gnt_v && gnt <= cur_id) begin
          load = 1'b1;
        end else begin
          dur_n = dur_cnt - DUR_W'(1);
          if (half_cnt >= div_r - DIV_W'(1)) begin
            half_n  = '0;
            phase_n = ~phase;
          end else begin
            half_n = half_cnt + DIV_W'(1);
          end
        end
      end
      S_GAP: begin
        if (gnt_v && gnt < cur_id) begin
          load = 1'b1;
        end else begin
          gap_n = (gap_cnt == 16'd0) ? 16'd0 : gap_cnt - 16'd1;
          if (gap_cnt <= 16'd1) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (load) begin
      pend_n[gnt] = 1'b0;
      ack_n[gnt]  = 1'b1;
      id_n        = gnt;
      dur_n       = ld_dur;
      div_n       = ld_div;
      half_n      = '0;
      phase_n     = 1'b1;
      state_n     = S_PLAY;
    end
    // New edges land after the grant clear so they are never lost.
    pend_n = pend_n | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pend     <= '0;
      req_prev <= '1;
      dur_cnt  <= '0;
      half_cnt <= '0;
      div_r    <= '0;
      phase    <= 1'b0;
      gap_cnt  <= '0;
      cur_id   <= '0;
      ack      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      req_prev <= req;
      dur_cnt  <= dur_n;
      half_cnt <= half_n;
      div_r    <= div_n;
      phase    <= phase_n;
      gap_cnt  <= gap_n;
      cur_id   <= id_n;
      ack      <= ack_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: vector table, directed sequences and random traffic
// against a time-based reference model of the effect scheduler.
module tb_sfx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [3:0]  vol_num = 4'd5;
  logic [15:0] audio;
  logic        busy;
  logic [1:0]  cur_id;
  logic [3:0]  ack;
  logic        done;

  always #5 clk = ~clk;

  sfx_scheduler #(
    .NUM_REQ(4),
    .DIV_W(22),
    .DUR_W(32),
    .DIV_TABLE({22'd4, 22'd3, 22'd3, 22'd2}),
    .DUR_TABLE({32'd20, 32'd9, 32'd9, 32'd12}),
    .GAP_CYCLES(16'd3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .vol_num(vol_num),
    .audio(audio),
    .busy(busy),
    .cur_id(cur_id),
    .ack(ack),
    .done(done)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: tracks when the current effect started and derives
  // waveform, completion and gap end from elapsed time.
  int m_div [4] = '{2, 3, 3, 4};
  int m_dur [4] = '{12, 9, 9, 20};

  typedef struct {
    int         st;
    logic [3:0] pend;
    logic [3:0] prev;
    int         id;
    longint     t0;
    longint     gend;
    logic [3:0] ack;
    logic       done;
    bit         valid;
    longint     n;
  } mdl_t;

  mdl_t m = '{0, 4'h0, 4'hF, 0, 0, 0, 4'h0, 1'b0, 1'b0, 0};

  function automatic logic [15:0] amp(input logic [3:0] v, input bit pos);
    logic [15:0] p;
    case (v)
      4'd5: p = 16'h4000;
      4'd4: p = 16'h3000;
      4'd3: p = 16'h2000;
      4'd2: p = 16'h1000;
      4'd1: p = 16'h0800;
      4'd0: p = 16'h0000;
      default: p = 16'h0400;
    endcase
    return pos ? p : (16'h0000 - p);
  endfunction

  function automatic mdl_t mstep(input mdl_t c, input logic rs,
                                 input logic [3:0] rq);
    mdl_t r;
    int g;
    bit ld;
    logic [3:0] rise;
    r = c;
    r.n = c.n + 1;
    r.ack = 4'h0;
    r.done = 1'b0;
    if (!rs) begin
      r.st = 0; r.pend = 4'h0; r.prev = 4'hF; r.id = 0; r.valid = 1'b1;
      return r;
    end
    rise = rq & ~c.prev;
    r.prev = rq;
    ld = 1'b0;
    g = -1;
    for (int i = 3; i >= 0; i--) if (c.pend[i]) g = i;
    case (c.st)
      0: ld = (g >= 0);
      1: begin
        if (r.n - c.t0 == longint'(m_dur[c.id])) begin
          r.done = 1'b1; r.st = 2; r.gend = r.n + 3;
        end else if (g >= 0 && g <= c.id) ld = 1'b1;
      end
      default: begin
        if (g >= 0 && g < c.id) ld = 1'b1;
        else if (r.n >= c.gend) r.st = 0;
      end
    endcase
    if (ld) begin
      r.pend[g] = 1'b0; r.ack[g] = 1'b1; r.id = g; r.t0 = r.n; r.st = 1;
    end
    r.pend = r.pend | rise;
    return r;
  endfunction

  function automatic logic [31:0] mexp(input mdl_t c, input logic [3:0] v);
    logic [15:0] ea;
    longint e;
    ea = 16'h0;
    if (c.st == 1) begin
      e = c.n - c.t0;
      ea = amp(v, ((e / m_div[c.id]) % 2) == 0);
    end
    return {8'd0, ea, c.st == 1, 2'(c.id), c.ack, c.done};
  endfunction

  always @(posedge clk) m <= mstep(m, rst_n, req);

  logic [15:0] lg_a  [64];
  logic        lg_b  [64];
  logic [1:0]  lg_id [64];
  logic [3:0]  lg_ack[64];
  logic        lg_dn [64];
  int          lk = 0;

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] v);
    rst_n = r; req = q; vol_num = v;
    @(posedge clk);
    @(negedge clk);
    if (m.valid)
      chk("model", {8'd0, audio, busy, cur_id, ack, done}, mexp(m, vol_num));
    if (lk < 64) begin
      lg_a[lk] = audio; lg_b[lk] = busy; lg_id[lk] = cur_id;
      lg_ack[lk] = ack; lg_dn[lk] = done;
      lk++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 4'h0, 4'd5);
  endtask

  function automatic int first_ack(input logic [3:0] mk, input int from);
    for (int i = from; i < lk; i++) if ((lg_ack[i] & mk) != 0) return i;
    return -1;
  endfunction

  function automatic int cnt_ack(input logic [3:0] mk);
    int c = 0;
    for (int i = 0; i < lk; i++) if ((lg_ack[i] & mk) != 0) c++;
    return c;
  endfunction

  function automatic int cnt_play(input logic [1:0] id, input int a, input int b);
    int c = 0;
    for (int i = a; i <= b && i < lk; i++) if (lg_b[i] && lg_id[i] == id) c++;
    return c;
  endfunction

  function automatic int cnt_done(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b && i < lk; i++) if (lg_dn[i]) c++;
    return c;
  endfunction

  function automatic int cnt_busy(input int a, input int b);
    int c = 0;
    for (int i = a; i <= b && i < lk; i++) if (lg_b[i]) c++;
    return c;
  endfunction

  typedef struct {
    logic        r;
    logic [3:0]  q;
    logic [3:0]  v;
    logic [15:0] a;
    logic        b;
    logic [1:0]  id;
    logic [3:0]  ak;
    logic        dn;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] q,
                              input logic [15:0] a, input logic b,
                              input logic [1:0] id, input logic [3:0] ak,
                              input logic dn);
    vec_t t;
    t.r = r; t.q = q; t.v = 4'd5; t.a = a; t.b = b;
    t.id = id; t.ak = ak; t.dn = dn;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [3:0] rq;
    logic [3:0] vv;
    logic       rr;

    // Reset with all requests held, release, then one id3 effect.
    tbl.push_back(mk(1'b0, 4'hF, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0));
    tbl.push_back(mk(1'b0, 4'hF, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'hF, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'h0, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'h8, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0));
    for (int e = 0; e < 20; e++)
      tbl.push_back(mk(1'b1, 4'h0, ((e / 4) % 2 == 0) ? 16'h4000 : 16'hC000,
                       1'b1, 2'd3, (e == 0) ? 4'h8 : 4'h0, 1'b0));
    tbl.push_back(mk(1'b1, 4'h0, 16'h0, 1'b0, 2'd3, 4'h0, 1'b1));
    for (int e = 0; e < 4; e++)
      tbl.push_back(mk(1'b1, 4'h0, 16'h0, 1'b0, 2'd3, 4'h0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].q, tbl[i].v);
      chk($sformatf("vec%0d", i), {8'd0, audio, busy, cur_id, ack, done},
          {8'd0, tbl[i].a, tbl[i].b, tbl[i].id, tbl[i].ak, tbl[i].dn});
    end

    // Simultaneous id0 + id3.
    idle(4);
    lk = 0;
    for (int k = 0; k < 45; k++) step(1'b1, (k == 0) ? 4'h9 : 4'h0, 4'd5);
    chk("sim_ack0", first_ack(4'h1, 0), 1);
    chk("sim_len0", cnt_play(2'd0, 0, 44), 12);
    chk("sim_done1", cnt_done(0, 16), 1);
    chk("sim_done_at", lg_dn[13], 1'b1);
    chk("sim_ack3", first_ack(4'h8, 0), 17);
    chk("sim_len3", cnt_play(2'd3, 0, 44), 20);
    chk("sim_done_all", cnt_done(0, 44), 2);

    // Preemption of id3 by id0.
    idle(6);
    lk = 0;
    for (int k = 0; k < 26; k++)
      step(1'b1, (k == 0) ? 4'h8 : ((k == 5) ? 4'h1 : 4'h0), 4'd5);
    chk("pre_ack0", first_ack(4'h1, 0), 6);
    chk("pre_len3", cnt_play(2'd3, 0, 25), 5);
    chk("pre_len0", cnt_play(2'd0, 0, 25), 12);
    chk("pre_nodone", cnt_done(0, 17), 0);
    chk("pre_done", cnt_done(18, 25), 1);
    chk("pre_ack3_once", cnt_ack(4'h8), 1);

    // Retrigger of id1 with id2 queued behind it.
    idle(6);
    lk = 0;
    for (int k = 0; k < 32; k++)
      step(1'b1, (k == 0 || k == 4) ? 4'h2 : ((k == 5) ? 4'h4 : 4'h0), 4'd5);
    chk("rt_ack1_cnt", cnt_ack(4'h2), 2);
    chk("rt_ack1_re", first_ack(4'h2, 2), 5);
    chk("rt_phase_old", lg_a[4], 16'hC000);
    chk("rt_phase_new", lg_a[5], 16'h4000);
    chk("rt_len1", cnt_play(2'd1, 0, 31), 13);
    chk("rt_done1", cnt_done(0, 17), 1);
    chk("rt_done_at", lg_dn[14], 1'b1);
    chk("rt_ack2", first_ack(4'h4, 0), 18);
    chk("rt_len2", cnt_play(2'd2, 0, 31), 9);

    // Mute, low volume, then reset mid-effect.
    idle(6);
    lk = 0;
    for (int k = 0; k < 21; k++) begin
      rr = (k != 10);
      vv = (k == 4 || k == 5) ? 4'd0 : ((k >= 6 && k <= 10) ? 4'd9 : 4'd5);
      step(rr, (k == 0) ? 4'h8 : 4'h0, vv);
    end
    chk("mute_audio", lg_a[4], 16'h0000);
    chk("mute_busy", lg_b[4], 1'b1);
    chk("vol9_a6", lg_a[6], 16'hFC00);
    chk("vol9_a8", lg_a[8], 16'hFC00);
    chk("vol9_a9", lg_a[9], 16'h0400);
    chk("rst_audio", lg_a[10], 16'h0000);
    chk("rst_busy", cnt_busy(10, 20), 0);
    chk("rst_nodone", cnt_done(0, 20), 0);

    // Random traffic against the model.
    rq = 4'h0;
    vv = 4'd5;
    for (int k = 0; k < 2500; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 15) == 0) rq[b] = ~rq[b];
      if ($urandom_range(0, 63) == 0) vv = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 399) != 0);
      step(rr, rq, vv);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
